// File: rtl/audio_capture.sv
// rtl/audio_capture.sv - PDM microphone capture into 8-bit samples for the sample RAM (option: AUDIO_CAPTURE_LOOP_EN)
module audio_capture #(
  parameter int ADDR_W       = 13,
  parameter int SAMPLE_DEPTH = 8192,
  parameter int MIC_CLK_DIV  = 12
) (
  input  logic              clk_25MHZ,
  input  logic              rst,
  input  logic              clk_8KHZ,
  input  logic              start,
  input  logic              stop,
  input  logic              mic_data,
  output logic              mic_clk,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   length
);

  localparam int DIV_W = $clog2(MIC_CLK_DIV + 1);
  localparam logic [DIV_W-1:0]  LP_DIV_LAST = DIV_W'(MIC_CLK_DIV - 1);
  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W + 1)'(SAMPLE_DEPTH);
  localparam logic [ADDR_W-1:0] LP_PTR_LAST = ADDR_W'(SAMPLE_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORD, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DIV_W-1:0]  r_div;
  logic              r_mic_clk;
  logic [1:0]        r_sync;
  logic [7:0]        r_ones;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_length;
  logic              r_stop_pend;

  logic              w_fall;
  logic              w_bit;
  logic [7:0]        w_sample;
  logic              w_full;
  logic              w_wr_req;
  logic              w_arm;
  logic              w_set_pend;

  // mic_clk falls on the cycle the divider wraps while the clock is high
  assign w_fall   = (r_div == LP_DIV_LAST) && r_mic_clk;
  assign w_bit    = w_fall && r_sync[1];
  // ones*2 saturated at 255: any count of 128 or more overflows
  assign w_sample = r_ones[7] ? 8'hFF : {r_ones[6:0], 1'b0};

`ifdef AUDIO_CAPTURE_LOOP_EN
  assign w_full = 1'b0;
`else
  assign w_full = (r_length == LP_DEPTH);
`endif

  assign mic_clk = r_mic_clk;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign length  = r_length;
  assign busy    = (r_state == S_ARMED) || (r_state == S_RECORD);
  assign done    = (r_state == S_DONE);

  // Free-running PDM clock divider
  always_ff @(posedge clk_25MHZ or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
    end else if (r_div == LP_DIV_LAST) begin
      r_div     <= '0;
      r_mic_clk <= ~r_mic_clk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous mic data
  always_ff @(posedge clk_25MHZ or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], mic_data};
  end

  // Ones counter per strobe window; a bit on the strobe cycle opens the new window
  always_ff @(posedge clk_25MHZ or posedge rst) begin
    if (rst)                          r_ones <= 8'd0;
    else if (clk_8KHZ)                r_ones <= {7'd0, w_bit};
    else if (w_bit && r_ones != 8'hFF) r_ones <= r_ones + 8'd1;
  end

  // State register
  always_ff @(posedge clk_25MHZ or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and write request; RECORD is left only after a pending write has been issued
  always_comb begin
    w_state_next = r_state;
    w_wr_req     = 1'b0;
    w_arm        = 1'b0;
    w_set_pend   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_ARMED;
          w_arm        = 1'b1;
        end
      end
      S_ARMED: begin
        if (stop)          w_state_next = S_DONE;
        else if (clk_8KHZ) w_state_next = S_RECORD;
      end
      S_RECORD: begin
        if (r_wr_en && (r_stop_pend || w_full)) begin
          w_state_next = S_DONE;
        end else if (stop && !clk_8KHZ) begin
          w_state_next = S_DONE;
        end else if (clk_8KHZ) begin
          w_wr_req   = 1'b1;
          w_set_pend = stop;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write port, take length and address pointer
  always_ff @(posedge clk_25MHZ or posedge rst) begin
    if (rst) begin
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_ptr       <= '0;
      r_length    <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_wr_en <= w_wr_req;
      if (w_arm) begin
        r_ptr       <= '0;
        r_length    <= '0;
        r_stop_pend <= 1'b0;
      end else if (w_wr_req) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_sample;
        r_ptr     <= (r_ptr == LP_PTR_LAST) ? '0 : r_ptr + 1'b1;
        if (r_length != LP_DEPTH) r_length <= r_length + 1'b1;
        if (w_set_pend) r_stop_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_capture.sv
// tb/tb_audio_capture.sv - scoreboard bench for audio_capture (SAMPLE_DEPTH=4)
module tb_audio_capture;

  localparam int ADDR_W = 13;
  localparam int WIN    = 3120;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_8KHZ = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              mic_data;
  logic              mic_clk;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   length;

  logic              mic_level = 1'b0;
  logic              alt_en = 1'b0;
  logic              alt_bit = 1'b0;
  logic              strobe_seen = 1'b0;
  logic [ADDR_W+7:0] sb[$];
  int                errors = 0;
  int                checks = 0;

  assign mic_data = alt_en ? alt_bit : mic_level;

  audio_capture #(.ADDR_W(ADDR_W), .SAMPLE_DEPTH(4), .MIC_CLK_DIV(12)) dut (
    .clk_25MHZ(clk), .rst(rst), .clk_8KHZ(clk_8KHZ), .start(start), .stop(stop),
    .mic_data(mic_data), .mic_clk(mic_clk), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .length(length)
  );

  always #20 clk = ~clk;

  always @(posedge mic_clk) alt_bit <= ~alt_bit;

  always @(posedge clk) strobe_seen <= clk_8KHZ;

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      checks++;
      if (strobe_seen !== 1'b1) begin
        errors++;
        $display("FAIL wr_latency: wr_en without strobe on previous cycle at %0t", $time);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, none expected", wr_addr, wr_data);
      end else begin
        logic [ADDR_W+7:0] exp;
        exp = sb.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          errors++;
          $display("FAIL write: addr=%0d data=%02h, expected addr=%0d data=%02h",
                   wr_addr, wr_data, exp[ADDR_W+7:8], exp[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  // strobe lands n cycles after the previous strobe; optionally expects a write
  task automatic strobe_after(input int n, input bit expect_wr, input int addr, input logic [7:0] data);
    tick(n - 1);
    if (expect_wr) sb.push_back({addr[ADDR_W-1:0], data});
    clk_8KHZ = 1'b1; tick(1); clk_8KHZ = 1'b0;
  endtask

  task automatic check_status(input string name, input logic exp_busy, input logic exp_done,
                              input int exp_len);
    checks++;
    if (busy !== exp_busy || done !== exp_done || length !== (ADDR_W+1)'(exp_len)) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b length=%0d, expected busy=%b done=%b length=%0d",
               name, busy, done, length, exp_busy, exp_done, exp_len);
    end
  endtask

  task automatic test_reset();
    #5;
    checks++;
    if (mic_clk !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: mic_clk=%b wr_en=%b addr=%0d data=%02h, expected all 0",
               mic_clk, wr_en, wr_addr, wr_data);
    end
    check_status("reset_status", 1'b0, 1'b0, 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    mic_level = 1'b0;
    pulse_start();
    strobe_after(50, 1'b0, 0, 8'h00);
    strobe_after(50, 1'b1, 0, 8'h00);
    tick(10);
    check_status("mid_record", 1'b1, 1'b0, 1);
    clk_8KHZ = 1'b1; tick(1); clk_8KHZ = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_wr_en: wr_en=%b, expected 0", wr_en);
    end
    check_status("async_reset", 1'b0, 1'b0, 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    strobe_after(50, 1'b0, 0, 8'h00);
    tick(5);
    check_status("idle_after_reset", 1'b0, 1'b0, 0);
  endtask

  task automatic test_tone();
    mic_level = 1'b1;
    tick(10);
    pulse_start();
    check_status("tone_armed", 1'b1, 1'b0, 0);
    strobe_after(20, 1'b0, 0, 8'h00);
    for (int i = 0; i < 3; i++) strobe_after(WIN, 1'b1, i, 8'hFF);
    tick(5);
    check_status("tone_len", 1'b1, 1'b0, 3);
    pulse_stop();
    tick(2);
    check_status("tone_stop", 1'b0, 1'b1, 3);
  endtask

  task automatic test_silence();
    mic_level = 1'b0;
    tick(10);
    pulse_start();
    strobe_after(20, 1'b0, 0, 8'h00);
    strobe_after(WIN, 1'b1, 0, 8'h00);
    tick(5);
    pulse_stop();
    tick(2);
    check_status("silence_stop", 1'b0, 1'b1, 1);
  endtask

  task automatic test_half();
    alt_en = 1'b1;
    tick(100);
    pulse_start();
    strobe_after(20, 1'b0, 0, 8'h00);
    strobe_after(WIN, 1'b1, 0, 8'h82);
    strobe_after(WIN, 1'b1, 1, 8'h82);
    tick(5);
    pulse_stop();
    tick(2);
    alt_en = 1'b0;
    check_status("half_stop", 1'b0, 1'b1, 2);
  endtask

  task automatic test_full();
    mic_level = 1'b0;
    tick(10);
    pulse_start();
    check_status("full_rearm", 1'b1, 1'b0, 0);
    strobe_after(20, 1'b0, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
`ifdef AUDIO_CAPTURE_LOOP_EN
      strobe_after(100, 1'b1, i % 4, 8'h00);
`else
      strobe_after(100, (i < 4), i, 8'h00);
`endif
    end
    tick(5);
`ifdef AUDIO_CAPTURE_LOOP_EN
    check_status("full_loop", 1'b1, 1'b0, 4);
    pulse_stop();
    tick(2);
`endif
    check_status("full_done", 1'b0, 1'b1, 4);
  endtask

  task automatic test_coincide();
    pulse_start();
    strobe_after(20, 1'b0, 0, 8'h00);
    tick(49);
    sb.push_back({ADDR_W'(0), 8'h00});
    clk_8KHZ = 1'b1; stop = 1'b1;
    tick(1);
    clk_8KHZ = 1'b0; stop = 1'b0;
    tick(3);
    check_status("coincide_stop", 1'b0, 1'b1, 1);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check_status("start_stop_done", 1'b1, 1'b0, 0);
    pulse_stop();
    tick(2);
    check_status("stop_armed", 1'b0, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_tone();
    test_silence();
    test_half();
    test_full();
    test_coincide();
    tick(20);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
